// File: rtl/alu_md_if.sv
// EX-stage ALU / multiply-divide bus bundle.
// The driver side (decode/stall logic) uses master; the unit uses slave.
interface alu_md_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [3:0]       ALU_OP;
    logic [WIDTH-1:0] ALU_OUT;
    logic             ZERO;
    logic             OVF;
    logic             MD_START;
    logic [1:0]       MD_OP;
    logic             HI_WE;
    logic             LO_WE;
    logic             MD_BUSY;
    logic             MD_DONE;
    logic [WIDTH-1:0] HI;
    logic [WIDTH-1:0] LO;

    modport master (
        output A, B, ALU_OP, MD_START, MD_OP, HI_WE, LO_WE,
        input  ALU_OUT, ZERO, OVF, MD_BUSY, MD_DONE, HI, LO
    );

    modport slave (
        input  A, B, ALU_OP, MD_START, MD_OP, HI_WE, LO_WE,
        output ALU_OUT, ZERO, OVF, MD_BUSY, MD_DONE, HI, LO
    );
endinterface

// File: rtl/alu_md.sv
// Combinational ALU plus iterative one-bit-per-cycle multiply/divide
// with architectural HI/LO registers.
module alu_md #(
    parameter int WIDTH = 32
) (
    input logic     clk,
    input logic     rst,
    alu_md_if.slave bus
);
    localparam int SHW = $clog2(WIDTH);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] FIN  = 2'd2;

    logic [WIDTH-1:0] a, b, sum, dif, res;
    logic [SHW-1:0]   shamt;
    logic             ovf;

    assign a     = bus.A;
    assign b     = bus.B;
    assign shamt = a[SHW-1:0];
    assign sum   = a + b;
    assign dif   = a - b;

    always_comb begin
        res = b << shamt;
        ovf = 1'b0;
        case (bus.ALU_OP)
            4'b0010: res = b >> shamt;
            4'b0011: res = $unsigned($signed(b) >>> shamt);
            4'b0100: res = {{(WIDTH-1){1'b0}}, a < b};
            4'b0101: res = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
            4'b1000: begin
                res = sum;
                ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            4'b1010: begin
                res = dif;
                ovf = (a[WIDTH-1] != b[WIDTH-1]) && (dif[WIDTH-1] != a[WIDTH-1]);
            end
            4'b1100: res = a & b;
            4'b1101: res = a | b;
            4'b1110: res = a ^ b;
            4'b1111: res = ~(a | b);
            default: res = b << shamt;
        endcase
    end

    assign bus.ALU_OUT = res;
    assign bus.ZERO    = (res == '0);
    assign bus.OVF     = ovf;

    logic [1:0]         state;
    logic [SHW:0]       cnt;
    logic               is_div, neg_q, neg_r, div_z;
    logic [WIDTH-1:0]   a_raw, m, q, hi, lo;
    logic [WIDTH:0]     r;
    logic               done;

    // Signed ops iterate on magnitudes; signs are restored in FIN.
    logic               sgn, a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag;

    assign sgn   = ~bus.MD_OP[0];
    assign a_neg = sgn & a[WIDTH-1];
    assign b_neg = sgn & b[WIDTH-1];
    assign a_mag = a_neg ? (~a + 1'b1) : a;
    assign b_mag = b_neg ? (~b + 1'b1) : b;

    logic [WIDTH:0]     mul_sum, shl, dsub;
    logic [2*WIDTH-1:0] prod, prod_f;
    logic [WIDTH-1:0]   quo_f, rem_f;

    assign mul_sum = {1'b0, r[WIDTH-1:0]} + {1'b0, (q[0] ? m : '0)};
    assign shl     = {r[WIDTH-1:0], q[WIDTH-1]};
    assign dsub    = shl - {1'b0, m};
    assign prod    = {r[WIDTH-1:0], q};
    assign prod_f  = neg_q ? (~prod + 1'b1) : prod;
    assign quo_f   = neg_q ? (~q + 1'b1) : q;
    assign rem_f   = neg_r ? (~r[WIDTH-1:0] + 1'b1) : r[WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            is_div <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            div_z  <= 1'b0;
            a_raw  <= '0;
            m      <= '0;
            q      <= '0;
            r      <= '0;
            hi     <= '0;
            lo     <= '0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.HI_WE) hi <= a;
                    if (bus.LO_WE) lo <= a;
                    if (bus.MD_START) begin
                        is_div <= bus.MD_OP[1];
                        neg_q  <= a_neg ^ b_neg;
                        neg_r  <= a_neg;
                        div_z  <= (b == '0);
                        a_raw  <= a;
                        m      <= b_mag;
                        q      <= a_mag;
                        r      <= '0;
                        cnt    <= (SHW+1)'(WIDTH);
                        state  <= CALC;
                    end
                end
                CALC: begin
                    cnt <= cnt - 1'b1;
                    if (is_div) begin
                        if (!dsub[WIDTH]) begin
                            r <= dsub;
                            q <= {q[WIDTH-2:0], 1'b1};
                        end else begin
                            r <= shl;
                            q <= {q[WIDTH-2:0], 1'b0};
                        end
                    end else begin
                        r <= {1'b0, mul_sum[WIDTH:1]};
                        q <= {mul_sum[0], q[WIDTH-1:1]};
                    end
                    if (cnt == (SHW+1)'(1)) state <= FIN;
                end
                FIN: begin
                    if (!is_div) begin
                        {hi, lo} <= prod_f;
                    end else if (div_z) begin
                        hi <= a_raw;
                        lo <= '1;
                    end else begin
                        hi <= rem_f;
                        lo <= quo_f;
                    end
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.MD_BUSY = (state != IDLE);
    assign bus.MD_DONE = done;
    assign bus.HI      = hi;
    assign bus.LO      = lo;
endmodule

// File: tb/tb_alu_md.sv
// Directed bench for alu_md: ALU ops, mult/div results and timing,
// busy interlock and mid-operation reset.
module tb_alu_md;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;
    int   n;

    alu_md_if #(.WIDTH(32)) bus ();

    alu_md #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic alu(input string tag, input logic [3:0] op,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input logic exp_ovf);
        bus.ALU_OP = op;
        bus.A      = a;
        bus.B      = b;
        #1;
        chk(tag, 64'(bus.ALU_OUT), 64'(exp));
        chk({tag, "_ovf"}, 64'(bus.OVF), 64'(exp_ovf));
        chk({tag, "_zero"}, 64'(bus.ZERO), 64'(exp == 32'd0));
    endtask

    task automatic launch(input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b);
        bus.A        = a;
        bus.B        = b;
        bus.MD_OP    = op;
        bus.MD_START = 1'b1;
        step();
        bus.MD_START = 1'b0;
    endtask

    task automatic wait_done(output int busy_n);
        busy_n = 0;
        for (int i = 0; i < 100; i++) begin
            chk("busy_done_excl", 64'(bus.MD_BUSY & bus.MD_DONE), 64'd0);
            if (bus.MD_DONE) break;
            if (bus.MD_BUSY) busy_n++;
            step();
        end
        chk("done_seen", 64'(bus.MD_DONE), 64'd1);
    endtask

    task automatic md(input string tag, input logic [1:0] op,
                      input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] ehi, input logic [31:0] elo);
        int cyc;
        launch(op, a, b);
        wait_done(cyc);
        chk({tag, "_busy_cycles"}, 64'(cyc), 64'd33);
        chk({tag, "_hi"}, 64'(bus.HI), 64'(ehi));
        chk({tag, "_lo"}, 64'(bus.LO), 64'(elo));
        step();
        chk({tag, "_done_pulse"}, 64'(bus.MD_DONE), 64'd0);
    endtask

    initial begin
        bus.A        = '0;
        bus.B        = '0;
        bus.ALU_OP   = '0;
        bus.MD_START = 1'b0;
        bus.MD_OP    = '0;
        bus.HI_WE    = 1'b0;
        bus.LO_WE    = 1'b0;
        step();
        step();
        rst = 1'b0;
        chk("rst_hi", 64'(bus.HI), 64'd0);
        chk("rst_lo", 64'(bus.LO), 64'd0);
        chk("rst_busy", 64'(bus.MD_BUSY), 64'd0);
        chk("rst_done", 64'(bus.MD_DONE), 64'd0);

        alu("sra", 4'b0011, 32'd4, 32'h8000_0000, 32'hF800_0000, 1'b0);
        alu("srl", 4'b0010, 32'd4, 32'h8000_0000, 32'h0800_0000, 1'b0);
        alu("sll", 4'b0000, 32'd4, 32'h0000_0001, 32'h0000_0010, 1'b0);
        alu("undef", 4'b0001, 32'd8, 32'h0000_00FF, 32'h0000_FF00, 1'b0);
        alu("slt", 4'b0101, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0);
        alu("sltu", 4'b0100, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0);
        alu("add_ovf", 4'b1000, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 1'b1);
        alu("add", 4'b1000, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0);
        alu("sub_ovf", 4'b1010, 32'h8000_0000, 32'd1, 32'h7FFF_FFFF, 1'b1);
        alu("sub", 4'b1010, 32'd5, 32'd7, 32'hFFFF_FFFE, 1'b0);
        alu("and", 4'b1100, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200, 1'b0);
        alu("or", 4'b1101, 32'hF000_0001, 32'h0000_0010, 32'hF000_0011, 1'b0);
        alu("xor", 4'b1110, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'd0, 1'b0);
        alu("nor", 4'b1111, 32'd0, 32'h0000_FFFF, 32'hFFFF_0000, 1'b0);

        md("mult", 2'b00, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
        md("multu", 2'b01, 32'hFFFF_FFFE, 32'd3, 32'h0000_0002, 32'hFFFF_FFFA);
        md("div", 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        md("div_mneg", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000);
        md("divu", 2'b11, 32'd100, 32'd7, 32'd2, 32'd14);
        md("divu_z", 2'b11, 32'h1234, 32'd0, 32'h1234, 32'hFFFF_FFFF);
        md("div_z", 2'b10, 32'hFFFF_FFF0, 32'd0, 32'hFFFF_FFF0, 32'hFFFF_FFFF);

        // Busy interlock: restart and mthi during CALC must not disturb.
        launch(2'b00, 32'd5, 32'd7);
        for (int i = 0; i < 5; i++) step();
        bus.A        = 32'd9;
        bus.B        = 32'd9;
        bus.MD_OP    = 2'b01;
        bus.MD_START = 1'b1;
        bus.HI_WE    = 1'b1;
        step();
        bus.MD_START = 1'b0;
        bus.HI_WE    = 1'b0;
        chk("ilk_hi_held", 64'(bus.HI), 64'hFFFF_FFF0);
        wait_done(n);
        chk("ilk_busy_cycles", 64'(n), 64'd27);
        chk("ilk_hi", 64'(bus.HI), 64'd0);
        chk("ilk_lo", 64'(bus.LO), 64'd35);

        // Start accepted in the DONE cycle.
        launch(2'b11, 32'd100, 32'd7);
        chk("b2b_busy", 64'(bus.MD_BUSY), 64'd1);
        wait_done(n);
        chk("b2b_busy_cycles", 64'(n), 64'd33);
        chk("b2b_hi", 64'(bus.HI), 64'd2);
        chk("b2b_lo", 64'(bus.LO), 64'd14);
        step();

        bus.A     = 32'h55;
        bus.LO_WE = 1'b1;
        step();
        bus.LO_WE = 1'b0;
        chk("mtlo", 64'(bus.LO), 64'h55);
        chk("mtlo_hi", 64'(bus.HI), 64'd2);
        bus.A     = 32'hABCD;
        bus.HI_WE = 1'b1;
        step();
        bus.HI_WE = 1'b0;
        chk("mthi", 64'(bus.HI), 64'hABCD);

        // Reset in the middle of CALC aborts cleanly.
        launch(2'b00, 32'd6, 32'd7);
        for (int i = 0; i < 10; i++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mrst_hi", 64'(bus.HI), 64'd0);
        chk("mrst_lo", 64'(bus.LO), 64'd0);
        chk("mrst_busy", 64'(bus.MD_BUSY), 64'd0);
        chk("mrst_done", 64'(bus.MD_DONE), 64'd0);
        for (int i = 0; i < 40; i++) begin
            step();
            if (bus.MD_DONE || bus.MD_BUSY) break;
        end
        chk("mrst_quiet", 64'({bus.MD_DONE, bus.MD_BUSY}), 64'd0);
        chk("mrst_lo_kept", 64'(bus.LO), 64'd0);
        md("post_rst", 2'b00, 32'h0001_0000, 32'h0001_0000, 32'd1, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/alu_md.md
Name: alu_md

Overview:
- Parametrised successor to the single-cycle datapath ALU.
- Keeps the combinational ALU operations at WIDTH bits and adds signed/unsigned less-than, zero and overflow flags.
- Adds an iterative multiply/divide unit with architectural HI/LO registers, used for mult/multu/div/divu/mfhi/mflo/mthi/mtlo.
- Sits in the EX stage; the stall logic uses MD_BUSY to hold mfhi/mflo and a new MD_START.

Parameters:
- WIDTH, 32, operand/result width in bits; must be an even value ≥ 8.
- SHW, clog2(WIDTH), derived shift-amount width; not to be overridden.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous active-high reset
- A  in  WIDTH  first operand; shift amount in A[SHW-1:0]; mthi/mtlo data
- B  in  WIDTH  second operand; data being shifted
- ALU_OP  in  4  combinational operation select
- ALU_OUT  out  WIDTH  combinational result
- ZERO  out  1  ALU_OUT == 0
- OVF  out  1  signed overflow of add (1000) or sub (1010); 0 for other ops
- MD_START  in  1  launch a multiply/divide on A, B
- MD_OP  in  2  00 mult, 01 multu, 10 div, 11 divu
- HI_WE  in  1  mthi: HI <= A
- LO_WE  in  1  mtlo: LO <= A
- MD_BUSY  out  1  unit iterating
- MD_DONE  out  1  one-cycle pulse; HI/LO just updated
- HI  out  WIDTH  HI register
- LO  out  WIDTH  LO register

Behaviour:
- ALU_OP encodings (purely combinational, no latency):
  - 0000 sll: B << A[SHW-1:0]
  - 0010 srl: logical right shift
  - 0011 sra: arithmetic right shift, sign of B[WIDTH-1] replicated
  - 0100 sltu: unsigned A < B
  - 0101 slt: signed A < B
  - 1000 add: A + B
  - 1010 sub: A - B
  - 1100 and
  - 1101 or
  - 1110 xor
  - 1111 nor
  - Any other encoding behaves as 0000.
- slt/sltu produce 1 or 0 zero-extended to WIDTH.
- Add/sub wrap modulo 2^WIDTH. OVF is 1 when the operand signs and the result sign indicate signed overflow.
- Reset (synchronous): HI=0, LO=0, MD_BUSY=0, MD_DONE=0, FSM in IDLE. Reset mid-operation aborts the operation; no HI/LO update occurs.
- FSM has three states: IDLE -> CALC -> FIN -> IDLE.
- IDLE:
  - MD_START=1 at edge t0 latches A, B and MD_OP. For signed ops it latches the operand magnitudes and the result signs.
  - Counter loads WIDTH; next state is CALC.
- CALC:
  - Exactly one bit per cycle: shift-add for multiply, restoring shift-subtract for divide.
  - Counter decrements each cycle; after WIDTH cycles the next state is FIN.
- FIN (one cycle):
  - Applies sign correction and writes HI/LO; next state is IDLE.
  - MD_DONE=1 during the cycle after that write edge.
- Timing: MD_BUSY=1 from edge t0+1 through edge t0+WIDTH+1 inclusive. HI/LO take the new values at edge t0+WIDTH+1; MD_DONE is high in the following cycle. Total latency is WIDTH+1 edges, and a new MD_START is accepted in the MD_DONE cycle.
- Multiply: {HI,LO} = full 2*WIDTH-bit product, two's-complement for mult, unsigned for multu.
- Divide:
  - LO = quotient truncated toward zero; HI = remainder with the sign of the dividend A.
  - Signed most-negative / -1 gives LO = most negative value, HI = 0.
- Divide by zero: normal latency, no error. Result is HI = A and LO = all ones, for both signed and unsigned.
- MD_START while MD_BUSY=1 is ignored; the running operation is unaffected.
- HI_WE/LO_WE:
  - Applied at the edge only when MD_BUSY=0.
  - Ignored while busy, and ignored at the FIN write edge.
  - HI_WE/LO_WE together with MD_START in IDLE: the writes are applied, the operation launches from the latched A/B, and its result later overwrites HI/LO.
- MD_BUSY and MD_DONE are never high in the same cycle.

Test Plan:
- ALU ops, WIDTH=32, combinational checks:
  - ALU_OP=0011, A=4, B=0x80000000 -> ALU_OUT=0xF8000000.
  - ALU_OP=0101, A=0xFFFFFFFF, B=1 -> 1.
  - ALU_OP=0100 with the same operands -> 0.
  - ALU_OP=1000, A=0x7FFFFFFF, B=1 -> ALU_OUT=0x80000000, OVF=1.
- mult:
  - A=0xFFFFFFFE (-2), B=3, MD_OP=00, pulse MD_START -> MD_BUSY for 33 cycles, then MD_DONE one cycle, HI=0xFFFFFFFF, LO=0xFFFFFFFA.
  - multu on the same operands -> HI=0x00000002, LO=0xFFFFFFFA.
- div:
  - A=-7, B=2, MD_OP=10 -> LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1).
  - A=0x80000000, B=0xFFFFFFFF, div -> LO=0x80000000, HI=0.
- divu by zero: A=0x1234, B=0, MD_OP=11 -> normal latency, HI=0x1234, LO=0xFFFFFFFF.
- Busy interlock:
  - Second MD_START and HI_WE issued mid-CALC -> ignored; the first result is intact.
  - MD_START in the MD_DONE cycle -> new operation accepted.
  - LO_WE with A=0x55 while idle -> LO=0x55 next cycle.
- Reset mid-CALC (cycle 10):
  - rst=1 -> next edge HI=LO=0, MD_BUSY=0, no MD_DONE.
  - A fresh mult launched afterwards completes correctly.
